id_ex_stage: RTL and testbench

//   ID/EX pipeline register directly upstream of the ALU. Captures decoded operands, funct code and

---
 rtl/id_ex_stage.sv | 112 +++++++++++
 tb/tb_id_ex_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded operands and handles stall/flush.
// Define ID_EX_FWD_EN to build EX/MEM and MEM/WB result forwarding onto the ALU operands.
module id_ex_stage #(
    parameter int Width    = 32,
    parameter int RegAddrW = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                id_valid,
    input  logic [Width-1:0]    id_rs_data,
    input  logic [Width-1:0]    id_rt_data,
    input  logic [RegAddrW-1:0] id_rs,
    input  logic [RegAddrW-1:0] id_rt,
    input  logic [RegAddrW-1:0] id_rd,
    input  logic [5:0]          id_funct,
    input  logic                id_regwrite,
    input  logic                exmem_regwrite,
    input  logic [RegAddrW-1:0] exmem_rd,
    input  logic [Width-1:0]    exmem_result,
    input  logic                memwb_regwrite,
    input  logic [RegAddrW-1:0] memwb_rd,
    input  logic [Width-1:0]    memwb_result,
    output logic                ex_valid,
    output logic [Width-1:0]    ex_in1,
    output logic [Width-1:0]    ex_in2,
    output logic [5:0]          ex_aluop,
    output logic [RegAddrW-1:0] ex_rd,
    output logic                ex_regwrite
);

    typedef struct packed {
        logic                valid;
        logic [Width-1:0]    rs_data;
        logic [Width-1:0]    rt_data;
        logic [RegAddrW-1:0] rs;
        logic [RegAddrW-1:0] rt;
        logic [RegAddrW-1:0] rd;
        logic [5:0]          funct;
        logic                regwrite;
    } stage_t;

    stage_t q;
    stage_t d;

    // A bubble is the all-zero stage, which also makes the ALU see 0 op 0.
    always_comb begin
        // NOTE: d gets a default before any branch so no path leaves it unassigned (no latch).
        d = q;
        if (flush) begin
            d = '0;
        end else if (stall) begin
            d = q;
        end else if (!id_valid) begin
            d = '0;
        end else begin
            d.valid    = 1'b1;
            d.rs_data  = id_rs_data;
            d.rt_data  = id_rt_data;
            d.rs       = id_rs;
            d.rt       = id_rt;
            d.rd       = id_rd;
            d.funct    = id_funct;
            d.regwrite = id_regwrite;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking so every stage register samples the same pre-edge values.
        if (rst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

    assign ex_valid    = q.valid;
    assign ex_aluop    = q.funct;
    assign ex_rd       = q.rd;
    assign ex_regwrite = q.regwrite & q.valid;

`ifdef ID_EX_FWD_EN
    // Younger producer (EX/MEM) wins; register 0 is hard-wired and never forwarded.
    function automatic logic [Width-1:0] fwd(
        input logic [RegAddrW-1:0] idx,
        input logic [Width-1:0]    held
    );
        logic [Width-1:0] v;
        v = held;
        if (idx != '0) begin
            if (exmem_regwrite && (exmem_rd == idx)) begin
                v = exmem_result;
            end else if (memwb_regwrite && (memwb_rd == idx)) begin
                v = memwb_result;
            end
        end
        return v;
    endfunction

    assign ex_in1 = fwd(q.rs, q.rs_data);
    assign ex_in2 = fwd(q.rt, q.rt_data);
`else
    logic unused_fwd;

    assign ex_in1 = q.rs_data;
    assign ex_in2 = q.rt_data;
    assign unused_fwd = ^{exmem_regwrite, exmem_rd, exmem_result,
                          memwb_regwrite, memwb_rd, memwb_result, q.rs, q.rt};
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed corner cases then randomized traffic vs a slot model.
module tb_id_ex_stage;

    localparam int W = 32;
    localparam int A = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         stall = 1'b0;
    logic         flush = 1'b0;
    logic         id_valid = 1'b0;
    logic [W-1:0] id_rs_data = '0;
    logic [W-1:0] id_rt_data = '0;
    logic [A-1:0] id_rs = '0;
    logic [A-1:0] id_rt = '0;
    logic [A-1:0] id_rd = '0;
    logic [5:0]   id_funct = '0;
    logic         id_regwrite = 1'b0;
    logic         exmem_regwrite = 1'b0;
    logic [A-1:0] exmem_rd = '0;
    logic [W-1:0] exmem_result = '0;
    logic         memwb_regwrite = 1'b0;
    logic [A-1:0] memwb_rd = '0;
    logic [W-1:0] memwb_result = '0;
    logic         ex_valid;
    logic [W-1:0] ex_in1;
    logic [W-1:0] ex_in2;
    logic [5:0]   ex_aluop;
    logic [A-1:0] ex_rd;
    logic         ex_regwrite;

    id_ex_stage #(.Width(W), .RegAddrW(A)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_funct(id_funct), .id_regwrite(id_regwrite),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_aluop(ex_aluop),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         valid;
        logic [W-1:0] in1;
        logic [W-1:0] in2;
        logic [5:0]   aluop;
        logic [A-1:0] rd;
        logic         we;
    } out_t;

    // The instruction sitting in EX, or a bubble (valid=0, everything else 0).
    typedef struct {
        logic         valid;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [A-1:0] rs;
        logic [A-1:0] rt;
        logic [A-1:0] rd;
        logic [5:0]   op;
        logic         we;
    } slot_t;

    slot_t m;
    out_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_pass = 0;

    task automatic check(input string name, input out_t act, input out_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got v=%0b in1=%h in2=%h op=%h rd=%0d we=%0b, want v=%0b in1=%h in2=%h op=%h rd=%0d we=%0b",
                      name, act.valid, act.in1, act.in2, act.aluop, act.rd, act.we,
                      exp.valid, exp.in1, exp.in2, exp.aluop, exp.rd, exp.we);
    endtask

`ifdef ID_EX_FWD_EN
    function automatic logic [W-1:0] fwd(input logic [A-1:0] idx, input logic [W-1:0] held);
        if (idx == 0) return held;
        if (exmem_regwrite && exmem_rd == idx) return exmem_result;
        if (memwb_regwrite && memwb_rd == idx) return memwb_result;
        return held;
    endfunction
`endif

    task automatic bubble();
        m = '{valid: 1'b0, a: '0, b: '0, rs: '0, rt: '0, rd: '0, op: '0, we: 1'b0};
    endtask

    // Advance one clock edge and move the model with the inputs present at that edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst || flush) bubble();
        else if (!stall) begin
            if (id_valid)
                m = '{valid: 1'b1, a: id_rs_data, b: id_rt_data, rs: id_rs, rt: id_rt,
                      rd: id_rd, op: id_funct, we: id_regwrite};
            else bubble();
        end
    endtask

    task automatic expect_now(input string name);
        out_t e;
        e.valid = m.valid;
        e.in1   = m.a;
        e.in2   = m.b;
`ifdef ID_EX_FWD_EN
        e.in1   = fwd(m.rs, m.a);
        e.in2   = fwd(m.rt, m.b);
`endif
        e.aluop = m.op;
        e.rd    = m.rd;
        e.we    = m.we && m.valid;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic set_id(input logic v, input logic [A-1:0] rs, input logic [A-1:0] rt,
                          input logic [A-1:0] rd, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [5:0] f, input logic we);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = a; id_rt_data = b; id_funct = f; id_regwrite = we;
    endtask

    task automatic set_fwd(input logic ew, input logic [A-1:0] er, input logic [W-1:0] ed,
                           input logic mw, input logic [A-1:0] mr, input logic [W-1:0] md);
        exmem_regwrite = ew; exmem_rd = er; exmem_result = ed;
        memwb_regwrite = mw; memwb_rd = mr; memwb_result = md;
    endtask

    task automatic rand_inputs();
        logic [5:0] f;
        case ($urandom_range(0, 2))
            0:       f = 6'b100000;
            1:       f = 6'b100010;
            default: f = 6'($urandom);
        endcase
        set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom), $urandom, $urandom, f, 1'($urandom));
        set_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom), 5'($urandom_range(0, 7)), $urandom);
    endtask

    // Monitor: compares the oldest expectation against the DUT on every falling edge.
    initial begin
        forever begin : mon
            out_t e;
            out_t a;
            string nm;
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {ex_valid, ex_in1, ex_in2, ex_aluop, ex_rd, ex_regwrite};
                check(nm, a, e);
            end
        end
    end

    initial begin
        bubble();
        #1;
        expect_now("reset");
        @(negedge clk);
        #1;
        rst = 1'b0;

        set_id(1'b1, 5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 6'b100000, 1'b1);
        tick();
        set_id(1'b1, 5'd3, 5'd4, 5'd5, 32'd1, 32'd2, 6'b100010, 1'b1);
        expect_now("first_capture");

        tick();
        set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
        stall = 1'b1;
        expect_now("fwd_exmem");
        tick();
        stall = 1'b0;
        set_fwd(1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
        set_id(1'b1, 5'd0, 5'd0, 5'd6, 32'h11, 32'h22, 6'b100000, 1'b1);
        expect_now("fwd_memwb");

        tick();
        set_fwd(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE);
        set_id(1'b1, 5'd5, 5'd6, 5'd9, 32'h1234, 32'h5678, 6'b100010, 1'b1);
        expect_now("no_fwd_r0");

        tick();
        set_fwd(1'b0, '0, '0, 1'b0, '0, '0);
        stall = 1'b1;
        expect_now("stall_capture");
        for (int j = 0; j < 3; j++) begin
            tick();
            if (j == 2) stall = 1'b0;
            set_id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom,
                   6'($urandom), 1'($urandom));
            expect_now("stall_hold");
        end

        stall = 1'b1;
        flush = 1'b1;
        tick();
        stall = 1'b0;
        flush = 1'b0;
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h9, 32'hA, 6'b100000, 1'b1);
        expect_now("flush_stall");

        tick();
        expect_now("pre_rst");
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        bubble();
        expect_now("rst_async");
        @(negedge clk);
        #1;
        rst = 1'b0;
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 6'b100000, 1'b1);
        tick();
        expect_now("post_rst_capture");

        for (int i = 0; i < 400; i++) begin
            tick();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            rand_inputs();
            expect_now("random");
        end

        repeat (2) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
